// File: rtl/button_event_ctrl_pkg.sv
// button_event_ctrl_pkg: shared FSM/owner encodings and width helper for the button event controller
package button_event_ctrl_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS    = 2'd1;
    localparam logic [1:0] REPEAT   = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    localparam logic OWN_UP = 1'b0;
    localparam logic OWN_DN = 1'b1;

    function automatic int ceillog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/event_tick_gen.sv
// event_tick_gen: free-running prescaler emitting a one-clk tick every N_TICK clocks, with sync clear
module event_tick_gen
    import button_event_ctrl_pkg::*;
#(
    parameter int N_TICK = 50000
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = ceillog2(N_TICK);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == W'(N_TICK - 1));

    // Count 0..N_TICK-1; restart on clear or on the terminal count.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p)
            r_cnt <= '0;
        else if (i_clr || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounced button levels to prioritised one-clk commands with long-press auto-repeat
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int N_TICK       = 50000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_clr,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic       repeat_active,
    output logic [1:0] state_o
);

    localparam int TW = ceillog2((HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS) + 1);

    logic [2:0]    r_sync1, r_sync2;
    logic [1:0]    r_state, w_nstate;
    logic          r_own, w_nown;
    logic [TW-1:0] r_tk, w_ntk, w_lim;
    logic          r_inc, r_dec, r_clr, r_rep;
    logic          w_inc, w_dec, w_clr;
    logic          w_up, w_dn, w_cl, w_any, w_own_lvl, w_tick, w_tmr_clr;

    assign w_up      = r_sync2[0];
    assign w_dn      = r_sync2[1];
    assign w_cl      = r_sync2[2];
    assign w_any     = |r_sync2;
    assign w_own_lvl = (r_own == OWN_UP) ? w_up : w_dn;
    assign w_tmr_clr = !(r_state == PRESS || r_state == REPEAT);
    assign w_lim     = (r_state == PRESS) ? TW'(HOLD_TICKS - 1) : TW'(REPEAT_TICKS - 1);

    event_tick_gen #(.N_TICK(N_TICK)) u_tick (
        .clk    (clk),
        .rst_a_p(rst_a_p),
        .i_clr  (w_tmr_clr),
        .o_tick (w_tick)
    );

    // Two-flop synchronisers; reset to pressed so a button held through reset is ignored.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {btn_clr, btn_dn, btn_up};
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and command decode: clear beats owner release beats tick.
    always_comb begin
        w_nstate = r_state;
        w_nown   = r_own;
        w_ntk    = r_tk;
        w_inc    = 1'b0;
        w_dec    = 1'b0;
        w_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cl) begin
                    w_clr    = 1'b1;
                    w_nstate = WAIT_REL;
                end else if (w_up || w_dn) begin
                    w_nown   = w_up ? OWN_UP : OWN_DN;
                    w_inc    = w_up;
                    w_dec    = !w_up;
                    w_ntk    = '0;
                    w_nstate = PRESS;
                end
            end
            PRESS, REPEAT: begin
                if (w_cl) begin
                    w_clr    = 1'b1;
                    w_nstate = WAIT_REL;
                end else if (!w_own_lvl) begin
                    w_nstate = w_any ? WAIT_REL : IDLE;
                end else if (w_tick) begin
                    if (r_tk == w_lim) begin
                        w_inc    = (r_own == OWN_UP);
                        w_dec    = (r_own == OWN_DN);
                        w_ntk    = '0;
                        w_nstate = REPEAT;
                    end else begin
                        w_ntk = r_tk + 1'b1;
                    end
                end
            end
            default: w_nstate = w_any ? WAIT_REL : IDLE;
        endcase
    end

    // State, tick counter and registered outputs; reset parks in WAIT_REL.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            r_state <= WAIT_REL;
            r_own   <= OWN_UP;
            r_tk    <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_clr   <= 1'b0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_own   <= w_nown;
            r_tk    <= w_ntk;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
            r_clr   <= w_clr;
            r_rep   <= (w_nstate == REPEAT);
        end
    end

    assign inc_pulse     = r_inc;
    assign dec_pulse     = r_dec;
    assign clr_pulse     = r_clr;
    assign repeat_active = r_rep;
    assign state_o       = r_state;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: segment table drives button levels; a pulse scoreboard checks command timing
module tb_button_event_ctrl;

    localparam logic [2:0] K_INC = 3'b001;
    localparam logic [2:0] K_DEC = 3'b010;
    localparam logic [2:0] K_CLR = 3'b100;

    logic       clk = 1'b0;
    logic       rst_a_p = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_clr = 1'b0;
    logic       inc_pulse, dec_pulse, clr_pulse, repeat_active;
    logic [1:0] state_o;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    typedef struct packed {
        int         cyc;
        logic [2:0] k;
    } exp_t;

    typedef struct packed {
        logic        up;
        logic        dn;
        logic        clr;
        logic [2:0]  pk;
        logic [63:0] pm;
        int          len;
        logic [1:0]  st;
        logic        rep;
        logic        rsa;
    } vec_t;

    exp_t q[$];
    vec_t tbl[$];
    vec_t v;

    button_event_ctrl #(.N_TICK(4), .HOLD_TICKS(3), .REPEAT_TICKS(2)) dut (
        .clk          (clk),
        .rst_a_p      (rst_a_p),
        .btn_up       (btn_up),
        .btn_dn       (btn_dn),
        .btn_clr      (btn_clr),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .clr_pulse    (clr_pulse),
        .repeat_active(repeat_active),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Edge counter: pulses are time-stamped with the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] b(input int i);
        return 64'd1 << i;
    endfunction

    function automatic vec_t mk(input int up, input int dn, input int clr, input logic [2:0] pk,
                                input logic [63:0] pm, input int len, input int st, input int rep,
                                input int rsa);
        return '{up[0], dn[0], clr[0], pk, pm, len, st[1:0], rep[0], rsa[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: flag overdue expectations, then match any observed pulse against the queue head.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_vec++;
            n_miss++;
            $display("FAIL missing pulse: kind %b due at cycle %0d never arrived", q[0].k, q[0].cyc);
            void'(q.pop_front());
        end
        if (!rst_a_p && (inc_pulse || dec_pulse || clr_pulse)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected pulse: got kind %b at cycle %0d, expected none",
                         {clr_pulse, dec_pulse, inc_pulse}, cyc);
            end else begin
                chk("pulse cycle", 32'(cyc), 32'(q[0].cyc));
                chk("pulse kind", 32'({clr_pulse, dec_pulse, inc_pulse}), 32'(q[0].k));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        // idle settle after reset
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 4, 0, 0, 0));
        // short press
        tbl.push_back(mk(1, 0, 0, K_INC, b(3), 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 6, 0, 0, 0));
        // long press: hold pulse at 15, repeats at 23, 31, 39
        tbl.push_back(mk(1, 0, 0, K_INC, b(3), 14, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, K_INC, b(1), 1, 2, 1, 0));
        tbl.push_back(mk(1, 0, 0, K_INC, b(8) | b(16) | b(24), 25, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 6, 0, 0, 0));
        // down press
        tbl.push_back(mk(0, 1, 0, K_DEC, b(3), 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 6, 0, 0, 0));
        // simultaneous up+dn: up wins, dn locked out until all released
        tbl.push_back(mk(1, 1, 0, K_INC, b(3), 6, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, K_INC, 64'd0, 6, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 5, 0, 0, 0));
        // clear lands on the repeat tick at 23
        tbl.push_back(mk(1, 0, 0, K_INC, b(3) | b(15), 20, 2, 1, 0));
        tbl.push_back(mk(1, 0, 1, K_CLR, b(3), 1, 2, 1, 0));
        tbl.push_back(mk(1, 0, 0, K_INC, 64'd0, 10, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 5, 0, 0, 0));
        // release seen on the repeat tick at 23
        tbl.push_back(mk(1, 0, 0, K_INC, b(3) | b(15), 20, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 4, 0, 0, 0));
        // reset while the hold pulse is high, button kept held
        tbl.push_back(mk(1, 0, 0, K_INC, b(3), 15, 2, 1, 1));
        tbl.push_back(mk(1, 0, 0, K_INC, 64'd0, 10, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 5, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, K_INC, b(3), 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, K_INC, 64'd0, 6, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 32'(state_o), 32'd3);
        chk("reset pulses", 32'({clr_pulse, dec_pulse, inc_pulse}), 32'd0);
        chk("reset repeat", 32'(repeat_active), 32'd0);
        rst_a_p = 1'b0;

        foreach (tbl[i]) begin
            v = tbl[i];
            btn_up  = v.up;
            btn_dn  = v.dn;
            btn_clr = v.clr;
            for (int j = 0; j < 64; j++)
                if (v.pm[j]) q.push_back('{cyc + j, v.pk});
            repeat (v.len) @(posedge clk);
            #1;
            chk($sformatf("vec %0d state", i), 32'(state_o), 32'(v.st));
            chk($sformatf("vec %0d repeat", i), 32'(repeat_active), 32'(v.rep));
            if (v.rsa) begin
                chk("pulse before reset", 32'(inc_pulse), 32'd1);
                #1;
                rst_a_p = 1'b1;
                #1;
                chk("async reset pulses", 32'({clr_pulse, dec_pulse, inc_pulse}), 32'd0);
                chk("async reset state", 32'(state_o), 32'd3);
                chk("async reset repeat", 32'(repeat_active), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                rst_a_p = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
